// File: rtl/btn_input_conditioner_pkg.sv
// rtl/btn_input_conditioner_pkg.sv - shared types and constants for the button input conditioner
//
// Purpose : debounce FSM state encoding, button role indices and default
//           sizing shared by btn_debounce and btn_input_conditioner.
// Ports   : none (package).

package btn_input_conditioner_pkg;

   // Per-button debounce FSM state, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DB_PRESS   = 2'd1,
      ST_PRESSED    = 2'd2,
      ST_DB_RELEASE = 2'd3
   } btn_state_t;

   // Button roles; the index is also the load priority (lower wins).
   localparam int BTN_LOAD_A  = 0;
   localparam int BTN_LOAD_B  = 1;
   localparam int BTN_LOAD_OP = 2;

   // Default sizing: 3 buttons, 6-bit ALU operand word, 10 ms at 100 MHz.
   localparam int NB_BTN_DEFAULT          = 3;
   localparam int NB_SW_DEFAULT           = 6;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus debounce FSM for one push-button
//
// Purpose : turns one raw asynchronous active-high button into a single
//           one-cycle pulse per accepted press. Both the press and the
//           release must be stable for DEBOUNCE_CYCLES synchronised cycles.
// Ports   :
//   clock      in   system clock
//   i_reset_n  in   asynchronous active-low reset
//   i_btn      in   raw asynchronous button level
//   o_pulse    out  registered one-cycle pulse on an accepted press
//   o_accept   out  combinational: the press is accepted at the coming edge
//                   (lets the parent register companion outputs on that edge)

module btn_debounce
   import btn_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic i_reset_n,
   input  logic i_btn,
   output logic o_pulse,
   output logic o_accept
);

   // Counter only has to reach DEBOUNCE_CYCLES-1; guard keeps width >= 1.
   localparam int                NB_CNT   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

   logic              btn_s1;
   logic              btn_s2;
   btn_state_t        state;
   logic [NB_CNT-1:0] cnt;
   logic              cnt_done;

   // Two-flop synchroniser; btn_s2 is the only stage the FSM looks at.
   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         btn_s1 <= i_btn;
         btn_s2 <= btn_s1;
      end
   end

   assign cnt_done = (cnt == CNT_LAST);
   assign o_accept = (state == ST_DB_PRESS) && btn_s2 && cnt_done;

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         o_pulse <= 1'b0;
      end else begin
         o_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (btn_s2) begin
                  state <= ST_DB_PRESS;
                  cnt   <= '0;
               end
            end
            ST_DB_PRESS: begin
               // Any low sample during the window rejects the press outright.
               if (!btn_s2) begin
                  state <= ST_IDLE;
               end else if (cnt_done) begin
                  state   <= ST_PRESSED;
                  o_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + NB_CNT'(1);
               end
            end
            ST_PRESSED: begin
               // Held indefinitely; no auto-repeat.
               if (!btn_s2) begin
                  state <= ST_DB_RELEASE;
                  cnt   <= '0;
               end
            end
            ST_DB_RELEASE: begin
               // Release bounce returns to PRESSED without a new pulse.
               if (btn_s2) begin
                  state <= ST_PRESSED;
               end else if (cnt_done) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + NB_CNT'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/btn_input_conditioner.sv
// rtl/btn_input_conditioner.sv - button/switch front end producing priority-resolved load strobes
//
// Purpose : synchronises the raw switch word, debounces every button and
//           emits one-cycle load strobes (A, B, operation) with the switch
//           word captured on the same edge.
// Ports   :
//   clock         in   system clock
//   i_reset_n     in   asynchronous active-low reset
//   i_btn         in   raw buttons, active-high (0 = load A, 1 = load B, 2 = load op)
//   i_sw          in   raw switch word
//   o_btn_pulse   out  one-cycle pulse per accepted press, all buttons
//   o_load        out  one-hot (or zero) strobe, lowest button index wins
//   o_sw_capture  out  synchronised switch word latched when a press is accepted
//   o_sw_sync     out  continuously synchronised switch word

module btn_input_conditioner
   import btn_input_conditioner_pkg::*;
#(
   parameter int NB_BTN          = NB_BTN_DEFAULT,
   parameter int NB_SW           = NB_SW_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic              clock,
   input  logic              i_reset_n,
   input  logic [NB_BTN-1:0] i_btn,
   input  logic [NB_SW-1:0]  i_sw,
   output logic [NB_BTN-1:0] o_btn_pulse,
   output logic [NB_BTN-1:0] o_load,
   output logic [NB_SW-1:0]  o_sw_capture,
   output logic [NB_SW-1:0]  o_sw_sync
);

   logic [NB_SW-1:0]  sw_s1;
   logic [NB_SW-1:0]  sw_s2;
   logic [NB_BTN-1:0] accept;
   logic [NB_BTN-1:0] load_next;

   genvar gi;
   generate
      for (gi = 0; gi < NB_BTN; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clock     (clock),
            .i_reset_n (i_reset_n),
            .i_btn     (i_btn[gi]),
            .o_pulse   (o_btn_pulse[gi]),
            .o_accept  (accept[gi])
         );
      end
   endgenerate

   // Switch word synchroniser; individual bits may skew by a cycle, which is
   // harmless because the word is only consumed after a debounced press.
   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= i_sw;
         sw_s2 <= sw_s1;
      end
   end

   assign o_sw_sync = sw_s2;

   // Isolate the lowest set bit (x & -x): lowest index has priority and
   // losing simultaneous presses are dropped.
   assign load_next = accept & (~accept + NB_BTN'(1));

   // Registered from the debouncers' accept terms so o_load and the capture
   // land on the same edge as o_btn_pulse.
   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_load       <= '0;
         o_sw_capture <= '0;
      end else begin
         o_load <= load_next;
         if (|accept) begin
            o_sw_capture <= sw_s2;
         end
      end
   end

endmodule

// File: tb/tb_btn_input_conditioner.sv
// tb/tb_btn_input_conditioner.sv - directed self-checking bench for btn_input_conditioner

module tb_btn_input_conditioner;
   import btn_input_conditioner_pkg::*;

   localparam int NB_BTN = 3;
   localparam int NB_SW  = 6;
   localparam int DB     = 4;

   logic              clock = 1'b0;
   logic              i_reset_n;
   logic [NB_BTN-1:0] i_btn;
   logic [NB_SW-1:0]  i_sw;
   logic [NB_BTN-1:0] o_btn_pulse;
   logic [NB_BTN-1:0] o_load;
   logic [NB_SW-1:0]  o_sw_capture;
   logic [NB_SW-1:0]  o_sw_sync;

   int checks   = 0;
   int failures = 0;

   int pulse_cnt [NB_BTN];
   int load_a_cnt   = 0;
   int load_b_cnt   = 0;
   int load_op_cnt  = 0;
   int multihot_cnt = 0;

   int base_p;
   int base_a;
   int base_b;
   int base_op;
   int base_mh;

   btn_input_conditioner #(
      .NB_BTN          (NB_BTN),
      .NB_SW           (NB_SW),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clock        (clock),
      .i_reset_n    (i_reset_n),
      .i_btn        (i_btn),
      .i_sw         (i_sw),
      .o_btn_pulse  (o_btn_pulse),
      .o_load       (o_load),
      .o_sw_capture (o_sw_capture),
      .o_sw_sync    (o_sw_sync)
   );

   always #5 clock = ~clock;

   // Event counters sampled mid-cycle, away from the active edge.
   always @(negedge clock) begin
      for (int b = 0; b < NB_BTN; b++) pulse_cnt[b] += int'(o_btn_pulse[b]);
      if (o_load == (3'b001 << BTN_LOAD_A))  load_a_cnt++;
      if (o_load == (3'b001 << BTN_LOAD_B))  load_b_cnt++;
      if (o_load == (3'b001 << BTN_LOAD_OP)) load_op_cnt++;
      if ($countones(o_load) > 1) multihot_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      for (int b = 0; b < NB_BTN; b++) pulse_cnt[b] = 0;

      // Reset state, switches non-zero to show the synchroniser is cleared
      i_reset_n = 1'b0;
      i_btn     = '0;
      i_sw      = 6'h3F;
      step(3);
      check("rst_pulse",   32'(o_btn_pulse),  32'h0);
      check("rst_load",    32'(o_load),       32'h0);
      check("rst_capture", 32'(o_sw_capture), 32'h0);
      check("rst_sw_sync", 32'(o_sw_sync),    32'h0);
      i_reset_n = 1'b1;
      i_sw      = 6'h00;
      step(3);

      // Clean press on load A
      base_p = pulse_cnt[0];
      base_a = load_a_cnt;
      i_btn  = 3'b001;
      i_sw   = 6'h2A;
      step(6);
      check("clean_pulse_early", 32'(o_btn_pulse), 32'h0);
      step(1);
      check("clean_pulse",   32'(o_btn_pulse),  32'h1);
      check("clean_load",    32'(o_load),       32'h1);
      check("clean_capture", 32'(o_sw_capture), 32'h2A);
      step(1);
      check("clean_pulse_end", 32'(o_btn_pulse),  32'h0);
      check("clean_load_end",  32'(o_load),       32'h0);
      check("clean_cap_hold",  32'(o_sw_capture), 32'h2A);
      step(12);
      i_btn = 3'b000;
      step(10);
      check("clean_pulse_count", 32'(pulse_cnt[0] - base_p), 32'd1);
      check("clean_load_count",  32'(load_a_cnt - base_a),   32'd1);

      // Bounce rejection on load B, then a stable press
      base_p = pulse_cnt[1];
      base_b = load_b_cnt;
      i_btn = 3'b010; step(1);
      i_btn = 3'b000; step(1);
      i_btn = 3'b010; step(1);
      i_btn = 3'b000; step(10);
      check("bounce_no_pulse", 32'(pulse_cnt[1] - base_p), 32'd0);
      i_btn = 3'b010; step(10);
      i_btn = 3'b000; step(10);
      check("bounce_then_press", 32'(pulse_cnt[1] - base_p), 32'd1);
      check("bounce_load_b",     32'(load_b_cnt - base_b),   32'd1);

      // Simultaneous presses: only load A strobes
      base_a  = load_a_cnt;
      base_b  = load_b_cnt;
      base_op = load_op_cnt;
      base_mh = multihot_cnt;
      i_btn = 3'b111;
      i_sw  = 6'h07;
      step(7);
      check("simul_pulse",   32'(o_btn_pulse),  32'h7);
      check("simul_load",    32'(o_load),       32'h1);
      check("simul_capture", 32'(o_sw_capture), 32'h07);
      step(10);
      i_btn = 3'b000;
      step(10);
      check("simul_load_a",   32'(load_a_cnt - base_a),    32'd1);
      check("simul_load_b",   32'(load_b_cnt - base_b),    32'd0);
      check("simul_load_op",  32'(load_op_cnt - base_op),  32'd0);
      check("simul_multihot", 32'(multihot_cnt - base_mh), 32'd0);

      // Release bounce: short low gap gives no new pulse, full release does
      base_p = pulse_cnt[0];
      i_btn = 3'b001; step(12);
      i_btn = 3'b000; step(2);
      i_btn = 3'b001; step(12);
      check("relbounce_one_pulse", 32'(pulse_cnt[0] - base_p), 32'd1);
      i_btn = 3'b000; step(8);
      i_btn = 3'b001; step(10);
      check("relbounce_second", 32'(pulse_cnt[0] - base_p), 32'd2);
      i_btn = 3'b000; step(10);

      // Capture hold across later switch changes
      i_btn = 3'b100;
      i_sw  = 6'h15;
      step(7);
      check("cap_pulse", 32'(o_btn_pulse),  32'h4);
      check("cap_load",  32'(o_load),       32'h4);
      check("cap_value", 32'(o_sw_capture), 32'h15);
      step(5);
      i_btn = 3'b000;
      step(10);
      i_sw = 6'h3F;
      step(1);
      check("cap_sync_stage1", 32'(o_sw_sync), 32'h15);
      step(1);
      check("cap_sync_stage2", 32'(o_sw_sync),    32'h3F);
      check("cap_hold",        32'(o_sw_capture), 32'h15);
      step(5);
      check("cap_hold_late",   32'(o_sw_capture), 32'h15);

      // Asynchronous reset during DB_PRESS, then re-debounce from IDLE
      base_p = pulse_cnt[0];
      i_btn = 3'b001;
      step(3);
      #3;
      i_reset_n = 1'b0;
      #1;
      check("arst_pulse",   32'(o_btn_pulse),  32'h0);
      check("arst_load",    32'(o_load),       32'h0);
      check("arst_capture", 32'(o_sw_capture), 32'h0);
      check("arst_sw_sync", 32'(o_sw_sync),    32'h0);
      step(2);
      i_reset_n = 1'b1;
      step(6);
      check("arst_pulse_early", 32'(o_btn_pulse), 32'h0);
      step(1);
      check("arst_pulse_after", 32'(o_btn_pulse),  32'h1);
      check("arst_load_after",  32'(o_load),       32'h1);
      check("arst_cap_after",   32'(o_sw_capture), 32'h3F);
      step(1);
      check("arst_pulse_single", 32'(o_btn_pulse), 32'h0);
      step(2);
      check("arst_pulse_count", 32'(pulse_cnt[0] - base_p), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
